fpga_cfg_loader: RTL and testbench

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

---
 rtl/fpga_cfg_pkg.sv | 21 ++
 rtl/fpga_cfg_loader_accum.sv | 41 ++++
 rtl/fpga_cfg_loader.sv | 169 ++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: FSM states, default
// geometry and the word-count helper.
package fpga_cfg_pkg;

  localparam int CFG_BITS_DEF = 116;
  localparam int DW_DEF       = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } cfg_state_e;

  // Number of DW-bit words needed to cover cfg_bits (rounded up).
  function automatic int cfg_nwords(input int cfg_bits, input int dw);
    return (cfg_bits + dw - 1) / dw;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_accum.sv
// Running XOR checksum of the configuration words; clear wins over enable.
module cfg_xor_accum
  import fpga_cfg_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] sum_o
);

  logic [DW-1:0] sum_q;
  logic [DW-1:0] sum_d;

  // Next accumulator value.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (enable_i) begin
      sum_d = sum_q ^ data_i;
    end else begin
      sum_d = sum_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Loads a configuration image word by word into a shadow register, verifies an
// XOR checksum and only then publishes the image to the fabric in one step.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int CFG_BITS = CFG_BITS_DEF,
  parameter int DW       = DW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic                cfg_valid,
  input  logic [DW-1:0]       cfg_data,
  output logic                cfg_ready,
  output logic [CFG_BITS-1:0] prog_out,
  output logic                fabric_en,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int NWORDS = cfg_nwords(CFG_BITS, DW);
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);

  cfg_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] prog_q, prog_d;
  logic                fab_en_q, fab_en_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic                acc_clr_s;
  logic                acc_en_s;
  logic [DW-1:0]       acc_sum_s;
  logic                xfer_s;
  logic [CFG_BITS-1:0] word_ext_s;
  logic [CFG_BITS-1:0] word_mask_s;

  assign xfer_s = cfg_valid & ready_q;

  // Place the incoming word at its slot; bits shifted past CFG_BITS fall away.
  assign word_ext_s  = CFG_BITS'(cfg_data) << (int'(cnt_q) * DW);
  assign word_mask_s = CFG_BITS'({DW{1'b1}}) << (int'(cnt_q) * DW);

  cfg_xor_accum #(
    .DW(DW)
  ) u_accum (
    .clk     (clk),
    .reset   (reset),
    .clear_i (acc_clr_s),
    .enable_i(acc_en_s),
    .data_i  (cfg_data),
    .sum_o   (acc_sum_s)
  );

  // Loader FSM and datapath next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    prog_d    = prog_q;
    fab_en_d  = fab_en_q;
    done_d    = 1'b0;
    err_d     = err_q;
    acc_clr_s = 1'b0;
    acc_en_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          shadow_d  = '0;
          err_d     = 1'b0;
          fab_en_d  = 1'b0;
          acc_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        // Abort beats a simultaneous transfer: the word is neither stored nor summed.
        if (cfg_abort) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else if (xfer_s) begin
          shadow_d = (shadow_q & ~word_mask_s) | (word_ext_s & word_mask_s);
          acc_en_s = 1'b1;
          if (cnt_q == LAST_WORD) begin
            state_d = ST_CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_CHECK: begin
        if (cfg_abort) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else if (xfer_s) begin
          if (cfg_data == acc_sum_s) begin
            state_d = ST_COMMIT;
          end else begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_COMMIT: begin
        prog_d   = shadow_q;
        fab_en_d = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end

      ST_ERROR: begin
        fab_en_d = 1'b0;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        fab_en_d = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      prog_q   <= '0;
      fab_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      prog_q   <= prog_d;
      fab_en_q <= fab_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign cfg_ready = ready_q;
  assign prog_out  = prog_q;
  assign fabric_en = fab_en_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Randomized directed bench for fpga_cfg_loader (DW=8 and DW=1 instances)
// against a word-array / XOR reference model.
module tb_fpga_cfg_loader;

  logic         clk = 1'b0;
  logic         reset;

  logic         start0, abort0, valid0;
  logic [7:0]   data0;
  logic         ready0, fab0, done0, err0;
  logic [115:0] prog0;

  logic         start1, abort1, valid1;
  logic [0:0]   data1;
  logic         ready1, fab1, done1, err1;
  logic [115:0] prog1;

  fpga_cfg_loader #(.CFG_BITS(116), .DW(8)) u_dut (
    .clk(clk), .reset(reset), .cfg_start(start0), .cfg_abort(abort0),
    .cfg_valid(valid0), .cfg_data(data0), .cfg_ready(ready0), .prog_out(prog0),
    .fabric_en(fab0), .cfg_done(done0), .cfg_err(err0)
  );

  fpga_cfg_loader #(.CFG_BITS(116), .DW(1)) u_dut1 (
    .clk(clk), .reset(reset), .cfg_start(start1), .cfg_abort(abort1),
    .cfg_valid(valid1), .cfg_data(data1), .cfg_ready(ready1), .prog_out(prog1),
    .fabric_en(fab1), .cfg_done(done1), .cfg_err(err1)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0]   w8 [15];
  logic [7:0]   ck8;
  logic [115:0] exp_prog0;
  logic [115:0] exp_prog1;
  logic [115:0] bits1;
  int           cyc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference image: word k occupies bits [8k+7:8k], truncated to 116 bits.
  function automatic logic [115:0] model_prog8();
    logic [119:0] full;
    full = '0;
    for (int k = 0; k < 15; k++) full[k*8 +: 8] = w8[k];
    return full[115:0];
  endfunction

  function automatic logic [7:0] model_sum8();
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 15; k++) s = s ^ w8[k];
    return s;
  endfunction

  task automatic run_load0(input bit gap, input bit good, input bit poke, output int cycles);
    int idx;
    ck8 = good ? model_sum8() : (model_sum8() ^ 8'($urandom_range(1, 255)));
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("start_ready", 128'(ready0), 128'(1'b1));
    check("start_fab_off", 128'(fab0), 128'(1'b0));
    check("start_err_clr", 128'(err0), 128'(1'b0));
    idx = 0;
    cycles = 0;
    while (idx < 16 && cycles < 200) begin
      valid0 = gap ? (cycles % 2 == 0) : 1'b1;
      if (idx < 15) data0 = w8[idx];
      else data0 = ck8;
      start0 = poke && (idx == 7);
      tick();
      if (valid0) idx++;
      cycles++;
    end
    valid0 = 1'b0;
    start0 = 1'b0;
    check("words_accepted", 128'(idx), 128'(16));
    if (good) begin
      check("commit_prog_hold", 128'(prog0), 128'(exp_prog0));
      check("commit_done_low", 128'(done0), 128'(1'b0));
      tick();
      exp_prog0 = model_prog8();
      check("prog_updated", 128'(prog0), 128'(exp_prog0));
      check("done_pulse", 128'(done0), 128'(1'b1));
      check("fab_en_on", 128'(fab0), 128'(1'b1));
      check("err_clear", 128'(err0), 128'(1'b0));
      tick();
      check("done_one_cycle", 128'(done0), 128'(1'b0));
      check("fab_en_hold", 128'(fab0), 128'(1'b1));
    end else begin
      check("bad_ck_err", 128'(err0), 128'(1'b1));
      check("bad_ck_fab", 128'(fab0), 128'(1'b0));
      check("bad_ck_prog", 128'(prog0), 128'(exp_prog0));
      check("bad_ck_no_done", 128'(done0), 128'(1'b0));
      tick();
      check("err_sticky", 128'(err0), 128'(1'b1));
      check("err_prog_hold", 128'(prog0), 128'(exp_prog0));
    end
  endtask

  task automatic run_load1(input bit good);
    int   idx;
    int   cycles;
    logic ck;
    bits1 = 116'({$urandom, $urandom, $urandom, $urandom});
    ck    = good ? ^bits1 : ~(^bits1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    idx = 0;
    cycles = 0;
    while (idx < 117 && cycles < 300) begin
      valid1 = 1'b1;
      if (idx < 116) data1[0] = bits1[idx];
      else data1[0] = ck;
      tick();
      idx++;
      cycles++;
    end
    valid1 = 1'b0;
    check("dw1_words", 128'(idx), 128'(117));
    if (good) begin
      tick();
      exp_prog1 = bits1;
      check("dw1_prog", 128'(prog1), 128'(exp_prog1));
      check("dw1_done", 128'(done1), 128'(1'b1));
      check("dw1_fab", 128'(fab1), 128'(1'b1));
    end else begin
      check("dw1_err", 128'(err1), 128'(1'b1));
      check("dw1_prog_hold", 128'(prog1), 128'(exp_prog1));
      check("dw1_fab_off", 128'(fab1), 128'(1'b0));
      tick();
    end
  endtask

  initial begin
    reset  = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; valid0 = 1'b0; data0 = 8'h00;
    start1 = 1'b0; abort1 = 1'b0; valid1 = 1'b0; data1 = 1'b0;
    exp_prog0 = '0;
    exp_prog1 = '0;
    #12;
    check("rst_prog", 128'(prog0), 128'(0));
    check("rst_fab", 128'(fab0), 128'(1'b0));
    check("rst_done", 128'(done0), 128'(1'b0));
    check("rst_err", 128'(err0), 128'(1'b0));
    check("rst_ready", 128'(ready0), 128'(1'b0));
    check("rst_prog_dw1", 128'(prog1), 128'(0));
    reset = 1'b1;
    tick();

    // Incrementing words; checksum from the XOR rule.
    for (int k = 0; k < 15; k++) w8[k] = 8'(k + 1);
    run_load0(1'b0, 1'b1, 1'b0, cyc);
    check("inc_cycles", 128'(cyc), 128'(16));
    check("inc_low_byte", 128'(prog0[7:0]), 128'(8'h01));
    check("inc_top_nib", 128'(prog0[115:112]), 128'(4'hF));

    // Same stream, corrupted checksum.
    run_load0(1'b0, 1'b0, 1'b0, cyc);

    // Random image, valid every other cycle, stray start mid-load.
    for (int k = 0; k < 15; k++) w8[k] = 8'($urandom);
    run_load0(1'b1, 1'b1, 1'b1, cyc);
    check("gap_cycles", 128'(cyc), 128'(31));

    // Abort in IDLE is ignored.
    abort0 = 1'b1;
    tick();
    abort0 = 1'b0;
    check("idle_abort_ready", 128'(ready0), 128'(1'b0));
    check("idle_abort_err", 128'(err0), 128'(1'b0));
    check("idle_abort_fab", 128'(fab0), 128'(1'b1));

    // Abort together with the 7th valid word.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      valid0 = 1'b1;
      data0  = w8[k];
      tick();
    end
    valid0 = 1'b1;
    abort0 = 1'b1;
    data0  = w8[6];
    tick();
    valid0 = 1'b0;
    abort0 = 1'b0;
    check("abort_err", 128'(err0), 128'(1'b1));
    check("abort_ready", 128'(ready0), 128'(1'b0));
    check("abort_fab", 128'(fab0), 128'(1'b0));
    check("abort_prog", 128'(prog0), 128'(exp_prog0));
    tick();
    for (int k = 0; k < 15; k++) w8[k] = 8'($urandom);
    run_load0(1'b0, 1'b1, 1'b0, cyc);

    // Reset mid-load after 5 words, away from any clock edge.
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid0 = 1'b1;
      data0  = w8[k];
      tick();
    end
    valid0 = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    exp_prog0 = '0;
    check("midrst_prog", 128'(prog0), 128'(exp_prog0));
    check("midrst_fab", 128'(fab0), 128'(1'b0));
    check("midrst_done", 128'(done0), 128'(1'b0));
    check("midrst_err", 128'(err0), 128'(1'b0));
    check("midrst_ready", 128'(ready0), 128'(1'b0));
    #2;
    reset = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) w8[k] = 8'($urandom);
    run_load0(1'b0, 1'b1, 1'b0, cyc);

    // One-bit word width with a parity checksum.
    run_load1(1'b1);
    run_load1(1'b0);
    run_load1(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
